// File: rtl/memory_access_scheduler.sv
// memory_access_scheduler: shares the program RAM (P) and video RAM (V) ports
// among instruction fetch, the load/store unit and display scanout. Each RAM
// port runs its own single-outstanding-access FSM (IDLE/ACCESS/READ_WAIT).
// P: ls beats fetch; V: scan beats ls. A per-port starvation counter forces
// the losing requester to win once it has waited STARVE_LIMIT cycles.
// Optional statistics counters are built when MEM_SCHED_STATS_EN is defined.
module memory_access_scheduler #(
  parameter int ADDRESS_WIDTH    = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int RAM_READ_LATENCY = 1,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_grant,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  input  logic                     ls_req,
  input  logic [2:0]               ls_op,
  input  logic [ADDRESS_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  output logic                     ls_grant,
  output logic                     ls_valid,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     ls_error,
  input  logic                     scan_req,
  input  logic [ADDRESS_WIDTH-1:0] scan_address,
  output logic                     scan_grant,
  output logic                     scan_valid,
  output logic [DATA_WIDTH-1:0]    scan_data,
  output logic                     p_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] p_ram_address,
  output logic [DATA_WIDTH-1:0]    p_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
  output logic                     v_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] v_ram_address,
  output logic [DATA_WIDTH-1:0]    v_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    v_ram_rdata
`ifdef MEM_SCHED_STATS_EN
  ,output logic [15:0]             stat_fetch_grants
  ,output logic [15:0]             stat_ls_grants
  ,output logic [15:0]             stat_scan_grants
  ,output logic [15:0]             stat_starve_events
`endif
);

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_LOADV  = 3'd3;
  localparam logic [2:0] OP_STOREV = 3'd4;
  localparam logic [2:0] OP_PEEK   = 3'd5;
  localparam logic [1:0] LAT       = 2'(RAM_READ_LATENCY);
  localparam logic [3:0] SLIM      = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_READ_WAIT} state_t;

  // P port state
  state_t                   p_state_q;
  logic                     p_own_ls_q;   // 1: current P access belongs to ls
  logic [1:0]               p_lat_q;
  logic [3:0]               p_starve_q, p_starve_d;
  logic                     p_rw_q;
  logic [ADDRESS_WIDTH-1:0] p_addr_q;
  logic [DATA_WIDTH-1:0]    p_wdata_q;
  // V port state
  state_t                   v_state_q;
  logic                     v_own_ls_q;   // 1: current V access belongs to ls
  logic [1:0]               v_lat_q;
  logic [3:0]               v_starve_q, v_starve_d;
  logic                     v_rw_q;
  logic [ADDRESS_WIDTH-1:0] v_addr_q;
  logic [DATA_WIDTH-1:0]    v_wdata_q;
  // requester-facing registers
  logic                     fetch_grant_q, fetch_valid_q;
  logic [DATA_WIDTH-1:0]    fetch_data_q;
  logic                     scan_grant_q, scan_valid_q;
  logic [DATA_WIDTH-1:0]    scan_data_q;
  logic                     ls_grant_q, ls_valid_q, ls_error_q, ls_pend_q, ls_ill_q;
  logic [DATA_WIDTH-1:0]    ls_rdata_q;

  // ls op decode; ls competes only when it has nothing outstanding
  logic ls_on_p, ls_on_v, ls_wr, ls_free, ls_p_req, ls_v_req, ls_ill_req;
  assign ls_on_p    = (ls_op == OP_LOAD) || (ls_op == OP_STORE) || (ls_op == OP_PEEK);
  assign ls_on_v    = (ls_op == OP_LOADV) || (ls_op == OP_STOREV);
  assign ls_wr      = (ls_op == OP_STORE) || (ls_op == OP_STOREV);
  assign ls_free    = ls_req & ~ls_pend_q;
  assign ls_p_req   = ls_free & ls_on_p;
  assign ls_v_req   = ls_free & ls_on_v;
  assign ls_ill_req = ls_free & ~ls_on_p & ~ls_on_v;

  // P arbitration: ls wins unless fetch has starved long enough
  logic p_idle, p_force, p_fetch_win, p_ls_win, p_rd_done, p_wr_done, fetch_busy;
  assign p_idle      = (p_state_q == ST_IDLE);
  assign p_force     = (p_starve_q >= SLIM);
  assign p_fetch_win = p_idle & fetch_req & (~ls_p_req | p_force);
  assign p_ls_win    = p_idle & ls_p_req & ~p_fetch_win;
  assign p_rd_done   = (p_state_q == ST_READ_WAIT) && (p_lat_q == LAT);
  assign p_wr_done   = (p_state_q == ST_ACCESS) && p_rw_q;
  assign fetch_busy  = ~p_idle & ~p_own_ls_q;
  assign p_starve_d  = p_fetch_win ? 4'd0 :
                       (fetch_req & ~fetch_busy & (p_starve_q < SLIM)) ? p_starve_q + 4'd1 :
                       p_starve_q;

  // V arbitration: scan wins unless ls has starved long enough
  logic v_idle, v_force, v_scan_win, v_ls_win, v_rd_done, v_wr_done;
  assign v_idle      = (v_state_q == ST_IDLE);
  assign v_force     = (v_starve_q >= SLIM);
  assign v_scan_win  = v_idle & scan_req & ~(ls_v_req & v_force);
  assign v_ls_win    = v_idle & ls_v_req & ~v_scan_win;
  assign v_rd_done   = (v_state_q == ST_READ_WAIT) && (v_lat_q == LAT);
  assign v_wr_done   = (v_state_q == ST_ACCESS) && v_rw_q;
  assign v_starve_d  = v_ls_win ? 4'd0 :
                       (ls_v_req & (v_starve_q < SLIM)) ? v_starve_q + 4'd1 :
                       v_starve_q;

  logic ls_done;
  assign ls_done = ((p_rd_done | p_wr_done) & p_own_ls_q) |
                   ((v_rd_done | v_wr_done) & v_own_ls_q) | ls_ill_q;

  // P port FSM plus fetch grant/valid/data
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_q <= ST_IDLE; p_own_ls_q <= 1'b0; p_lat_q <= 2'd0; p_starve_q <= 4'd0;
      p_rw_q <= 1'b0; p_addr_q <= '0; p_wdata_q <= '0;
      fetch_grant_q <= 1'b0; fetch_valid_q <= 1'b0; fetch_data_q <= '0;
    end else begin
      p_starve_q    <= p_starve_d;
      fetch_grant_q <= p_fetch_win;
      fetch_valid_q <= p_rd_done & ~p_own_ls_q;
      if (p_rd_done & ~p_own_ls_q) fetch_data_q <= p_ram_rdata;
      case (p_state_q)
        ST_IDLE: if (p_fetch_win | p_ls_win) begin
          p_state_q  <= ST_ACCESS;
          p_own_ls_q <= p_ls_win;
          p_addr_q   <= p_ls_win ? ls_address : fetch_address;
          p_rw_q     <= p_ls_win & ls_wr;
          if (p_ls_win) p_wdata_q <= ls_wdata;
        end
        ST_ACCESS: begin
          p_rw_q <= 1'b0;
          if (p_rw_q) p_state_q <= ST_IDLE;
          else begin p_state_q <= ST_READ_WAIT; p_lat_q <= 2'd1; end
        end
        ST_READ_WAIT: begin
          if (p_lat_q == LAT) p_state_q <= ST_IDLE;
          else p_lat_q <= p_lat_q + 2'd1;
        end
        default: p_state_q <= ST_IDLE;
      endcase
    end
  end

  // V port FSM plus scan grant/valid/data
  always_ff @(posedge clk) begin
    if (reset) begin
      v_state_q <= ST_IDLE; v_own_ls_q <= 1'b0; v_lat_q <= 2'd0; v_starve_q <= 4'd0;
      v_rw_q <= 1'b0; v_addr_q <= '0; v_wdata_q <= '0;
      scan_grant_q <= 1'b0; scan_valid_q <= 1'b0; scan_data_q <= '0;
    end else begin
      v_starve_q   <= v_starve_d;
      scan_grant_q <= v_scan_win;
      scan_valid_q <= v_rd_done & ~v_own_ls_q;
      if (v_rd_done & ~v_own_ls_q) scan_data_q <= v_ram_rdata;
      case (v_state_q)
        ST_IDLE: if (v_scan_win | v_ls_win) begin
          v_state_q  <= ST_ACCESS;
          v_own_ls_q <= v_ls_win;
          v_addr_q   <= v_ls_win ? ls_address : scan_address;
          v_rw_q     <= v_ls_win & ls_wr;
          if (v_ls_win) v_wdata_q <= ls_wdata;
        end
        ST_ACCESS: begin
          v_rw_q <= 1'b0;
          if (v_rw_q) v_state_q <= ST_IDLE;
          else begin v_state_q <= ST_READ_WAIT; v_lat_q <= 2'd1; end
        end
        ST_READ_WAIT: begin
          if (v_lat_q == LAT) v_state_q <= ST_IDLE;
          else v_lat_q <= v_lat_q + 2'd1;
        end
        default: v_state_q <= ST_IDLE;
      endcase
    end
  end

  // ls handshake: one outstanding access across P, V and illegal-op completion
  always_ff @(posedge clk) begin
    if (reset) begin
      ls_grant_q <= 1'b0; ls_valid_q <= 1'b0; ls_error_q <= 1'b0;
      ls_pend_q  <= 1'b0; ls_ill_q   <= 1'b0; ls_rdata_q <= '0;
    end else begin
      ls_grant_q <= p_ls_win | v_ls_win | ls_ill_req;
      ls_ill_q   <= ls_ill_req;
      ls_valid_q <= ls_done;
      ls_error_q <= ls_ill_q;
      if (ls_ill_q)                     ls_rdata_q <= '0;
      else if (p_rd_done & p_own_ls_q)  ls_rdata_q <= p_ram_rdata;
      else if (v_rd_done & v_own_ls_q)  ls_rdata_q <= v_ram_rdata;
      if (p_ls_win | v_ls_win | ls_ill_req) ls_pend_q <= 1'b1;
      else if (ls_done)                     ls_pend_q <= 1'b0;
    end
  end

  assign fetch_grant   = fetch_grant_q;
  assign fetch_valid   = fetch_valid_q;
  assign fetch_data    = fetch_data_q;
  assign scan_grant    = scan_grant_q;
  assign scan_valid    = scan_valid_q;
  assign scan_data     = scan_data_q;
  assign ls_grant      = ls_grant_q;
  assign ls_valid      = ls_valid_q;
  assign ls_error      = ls_error_q;
  assign ls_rdata      = ls_rdata_q;
  assign p_ram_rw      = p_rw_q;
  assign p_ram_address = p_addr_q;
  assign p_ram_wdata   = p_wdata_q;
  assign v_ram_rw      = v_rw_q;
  assign v_ram_address = v_addr_q;
  assign v_ram_wdata   = v_wdata_q;

`ifdef MEM_SCHED_STATS_EN
  logic [15:0] st_fetch_q, st_ls_q, st_scan_q, st_starve_q;
  logic [1:0]  starve_inc;
  // a forced win counts only when the override actually beat a rival request
  assign starve_inc = {1'b0, p_fetch_win & p_force & ls_p_req} +
                      {1'b0, v_ls_win & v_force & scan_req};

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // saturating grant / forced-win counters
  always_ff @(posedge clk) begin
    if (reset) begin
      st_fetch_q <= '0; st_ls_q <= '0; st_scan_q <= '0; st_starve_q <= '0;
    end else begin
      st_fetch_q  <= sat_add(st_fetch_q, {1'b0, p_fetch_win});
      st_ls_q     <= sat_add(st_ls_q, {1'b0, p_ls_win | v_ls_win | ls_ill_req});
      st_scan_q   <= sat_add(st_scan_q, {1'b0, v_scan_win});
      st_starve_q <= sat_add(st_starve_q, starve_inc);
    end
  end

  assign stat_fetch_grants  = st_fetch_q;
  assign stat_ls_grants     = st_ls_q;
  assign stat_scan_grants   = st_scan_q;
  assign stat_starve_events = st_starve_q;
`endif

endmodule

// File: doc/memory_access_scheduler.md
Name: memory_access_scheduler

Overview:
- Sequences and shares the program RAM and video RAM ports among three requesters:
  - instruction fetch (PC-addressed reads of program RAM)
  - the microcode load/store unit (LOAD/STORE/LOADV/STOREV/PEEK)
  - the display scanout reader (video RAM reads)
- Each RAM port has an independent single-outstanding-access FSM, so accesses to different RAMs proceed in parallel.
- Sits between the core/display and the two synchronous RAMs; replaces direct combinational routing of the memory path.

Parameters:
- ADDRESS_WIDTH, 16, width of all address buses
- DATA_WIDTH, 16, width of all data buses
- RAM_READ_LATENCY, 1, cycles from address presented to RAM rdata valid (1..3)
- STARVE_LIMIT, 4, consecutive cycles a losing requester waits before it is forced to win (1..15)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- fetch_req  input  1  fetch request, level
- fetch_address  input  ADDRESS_WIDTH  program RAM read address
- fetch_grant  output  1  one-cycle accept pulse
- fetch_valid  output  1  one-cycle read-data-valid pulse
- fetch_data  output  DATA_WIDTH  read data
- ls_req  input  1  load/store request, level
- ls_op  input  3  1=LOAD 2=STORE 3=LOADV 4=STOREV 5=PEEK, others illegal
- ls_address  input  ADDRESS_WIDTH  target address
- ls_wdata  input  DATA_WIDTH  store data
- ls_grant  output  1  one-cycle accept pulse
- ls_valid  output  1  completion pulse (reads and writes)
- ls_rdata  output  DATA_WIDTH  read data
- ls_error  output  1  pulses with ls_valid for an illegal op
- scan_req  input  1  scanout request, level
- scan_address  input  ADDRESS_WIDTH  video RAM read address
- scan_grant  output  1  accept pulse
- scan_valid  output  1  read-data-valid pulse
- scan_data  output  DATA_WIDTH  read data
- p_ram_rw  output  1  program RAM 0=read 1=write
- p_ram_address  output  ADDRESS_WIDTH  program RAM address
- p_ram_wdata  output  DATA_WIDTH  program RAM write data
- p_ram_rdata  input  DATA_WIDTH  program RAM read data
- v_ram_rw  output  1  video RAM 0=read 1=write
- v_ram_address  output  ADDRESS_WIDTH  video RAM address
- v_ram_wdata  output  DATA_WIDTH  video RAM write data
- v_ram_rdata  input  DATA_WIDTH  video RAM read data

Behaviour:
- Reset: all outputs 0, both port FSMs IDLE, starvation counters 0. Reset during a pending read discards it; no valid is issued afterwards.
- Routing by ls_op:
  - LOAD, STORE, PEEK → P port. PEEK is a program RAM read returned on ls_rdata.
  - LOADV, STOREV → V port.
  - Illegal op: accepted in any cycle without touching either RAM. ls_grant is asserted; next cycle ls_valid=1, ls_error=1, ls_rdata=0.
- Per-port FSM states: IDLE, ACCESS, READ_WAIT.
- IDLE: at a clock edge where at least one eligible request is present:
  - Register the winner's address, rw and wdata onto the RAM outputs.
  - Pulse the winner's grant for the following cycle; move to ACCESS.
- ACCESS:
  - Write: rw returns to 0 next cycle, the requester's valid pulses, FSM goes to IDLE. Write latency is grant+1.
  - Read: go to READ_WAIT and count RAM_READ_LATENCY cycles.
- READ_WAIT: capture rdata into the requester's data register, pulse valid, return to IDLE. Read valid occurs exactly RAM_READ_LATENCY+1 cycles after grant.
- Addresses: address and rw hold their last value while idle; rw is always 0 outside write ACCESS.
- Requester protocol: hold req/address/data stable until grant, deassert req the cycle after grant. A req still high when the port returns to IDLE is a new request. Data outputs hold their value between valid pulses.
- P port arbitration: ls beats fetch. A counter increments each cycle fetch is pending and loses; at STARVE_LIMIT fetch wins the next arbitration and the counter clears. The counter also clears whenever fetch wins.
- V port arbitration: scan beats ls (display timing), with the same STARVE_LIMIT mechanism protecting ls.
- Both ports may grant in the same cycle, e.g. fetch on P and LOADV on V. ls may hold only one outstanding access: no ls_grant while an ls access is pending on either port.

Optional Feature:
- Macro MEM_SCHED_STATS_EN.
- Defined: adds outputs stat_fetch_grants, stat_ls_grants, stat_scan_grants and stat_starve_events, each 16-bit.
  - Counters saturate at 0xFFFF and clear on reset.
  - stat_starve_events increments whenever a forced-win grant occurs.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch_req with fetch_address=0xBEEF and RAM_READ_LATENCY=1 → fetch_grant at T, p_ram_address=0xBEEF with p_ram_rw=0 at T, fetch_valid with fetch_data=p_ram_rdata at T+2.
- ls STOREV at address 0xAEAE, data 0xBBBB, scan idle → v_ram_rw=1, v_ram_address=0xAEAE, v_ram_wdata=0xBBBB for one cycle; ls_valid one cycle after grant.
- Same cycle: fetch_req at 0x0001 and ls LOADV at 0xEEEE → both grants pulse together; P and V reads complete in parallel.
- ls LOAD held continuously while fetch_req held → fetch granted at the first IDLE arbitration after waiting STARVE_LIMIT=4 cycles, and never later than that.
- ls_op=6 → ls_grant, then ls_valid=1, ls_error=1, ls_rdata=0; p_ram_rw and v_ram_rw remain 0.
- Assert reset during READ_WAIT → all outputs 0 the next cycle; no stale fetch_valid appears afterwards.
